// File: rtl/day10_pkg.sv
// Shared constants and types for the day-10 machine loader: ASCII tokens,
// loader/tokenizer state enums and default machine capacities.
package day10_pkg;

  localparam int unsigned DEF_MAX_NUM_LIGHTS  = 10;
  localparam int unsigned DEF_MAX_NUM_BUTTONS = 13;

  localparam logic [7:0] CH_LBRACK = 8'h5B;  // '['
  localparam logic [7:0] CH_RBRACK = 8'h5D;  // ']'
  localparam logic [7:0] CH_LPAREN = 8'h28;  // '('
  localparam logic [7:0] CH_RPAREN = 8'h29;  // ')'
  localparam logic [7:0] CH_COMMA  = 8'h2C;  // ','
  localparam logic [7:0] CH_LBRACE = 8'h7B;  // '{'
  localparam logic [7:0] CH_RBRACE = 8'h7D;  // '}'
  localparam logic [7:0] CH_DOT    = 8'h2E;  // '.'
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
  localparam logic [7:0] CH_NL     = 8'h0A;  // '\n'
  localparam logic [7:0] CH_CR     = 8'h0D;  // '\r'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '
  localparam logic [7:0] CH_ZERO   = 8'h30;  // '0'
  localparam logic [7:0] CH_NINE   = 8'h39;  // '9'

  typedef enum logic [2:0] {
    ST_PARSE,
    ST_LAUNCH,
    ST_WAIT,
    ST_COLLECT,
    ST_FINISH
  } loader_state_t;

  typedef enum logic [1:0] {
    CTX_IDLE,
    CTX_LIGHTS,
    CTX_BUTTON,
    CTX_JOLT
  } token_ctx_t;

  // Width needed to hold a count 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/day10_interfaces.sv
// Stream input, solver request and solver result interfaces used by the
// day-10 machine loader.
interface axi_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface day10_input_if #(
  parameter int unsigned MAX_NUM_LIGHTS  = day10_pkg::DEF_MAX_NUM_LIGHTS,
  parameter int unsigned MAX_NUM_BUTTONS = day10_pkg::DEF_MAX_NUM_BUTTONS
);
  logic [day10_pkg::cnt_w(MAX_NUM_LIGHTS)-1:0]  num_lights;
  logic [day10_pkg::cnt_w(MAX_NUM_BUTTONS)-1:0] num_buttons;
  logic [MAX_NUM_LIGHTS-1:0]                    buttons [MAX_NUM_BUTTONS];
  logic [MAX_NUM_LIGHTS-1:0]                    target_lights_arrangement;

  modport producer (output num_lights, output num_buttons, output buttons,
                    output target_lights_arrangement);
  modport consumer (input num_lights, input num_buttons, input buttons,
                    input target_lights_arrangement);
endinterface

interface day10_output_if #(
  parameter int unsigned MAX_NUM_BUTTONS = day10_pkg::DEF_MAX_NUM_BUTTONS
);
  logic [day10_pkg::cnt_w(MAX_NUM_BUTTONS)-1:0] min_button_presses;
  logic [MAX_NUM_BUTTONS-1:0]                   buttons_to_press;

  modport producer (output min_button_presses, output buttons_to_press);
  modport consumer (input min_button_presses, input buttons_to_press);
endinterface

// File: rtl/day10_line_parser.sv
// Byte-level tokenizer: accumulates one machine description per line and
// flags the line end, whether it is launchable, and format/capacity errors.
module day10_line_parser
  import day10_pkg::*;
#(
  parameter int unsigned MAX_NUM_LIGHTS  = DEF_MAX_NUM_LIGHTS,
  parameter int unsigned MAX_NUM_BUTTONS = DEF_MAX_NUM_BUTTONS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                beat,
  input  logic [7:0]                          data,
  input  logic                                last,
  input  logic                                clear,
  output logic                                line_done,
  output logic                                line_valid,
  output logic                                line_error,
  output logic [cnt_w(MAX_NUM_LIGHTS)-1:0]    num_lights,
  output logic [cnt_w(MAX_NUM_BUTTONS)-1:0]   num_buttons,
  output logic [MAX_NUM_LIGHTS-1:0]           target,
  output logic [MAX_NUM_LIGHTS-1:0]           buttons [MAX_NUM_BUTTONS]
);

  localparam int unsigned LW = cnt_w(MAX_NUM_LIGHTS);
  localparam int unsigned BW = cnt_w(MAX_NUM_BUTTONS);

  token_ctx_t                ctx, ctx_n;
  logic [LW-1:0]             idx, idx_n;
  logic [LW-1:0]             acc, acc_n;
  logic [MAX_NUM_LIGHTS-1:0] mask, mask_n;
  logic                      seen, seen_n;
  logic                      err, err_n;
  logic [LW-1:0]             nl_n;
  logic [BW-1:0]             nb_n;
  logic [MAX_NUM_LIGHTS-1:0] tgt_n;
  logic [MAX_NUM_LIGHTS-1:0] btn_n [MAX_NUM_BUTTONS];
  logic [31:0]               acc_ext;
  logic                      is_digit;
  logic                      line_end;
  logic                      unterminated;

  always_comb begin
    ctx_n    = ctx;
    idx_n    = idx;
    acc_n    = acc;
    mask_n   = mask;
    seen_n   = seen;
    err_n    = err;
    nl_n     = num_lights;
    nb_n     = num_buttons;
    tgt_n    = target;
    btn_n    = buttons;
    is_digit = (data >= CH_ZERO) && (data <= CH_NINE);
    acc_ext  = 32'(acc) * 32'd10 + 32'(data - CH_ZERO);
    if (beat && !err && data != CH_NL && data != CH_CR && data != CH_SPACE) begin
      case (ctx)
        CTX_IDLE: begin
          if (data == CH_LBRACK && !seen) begin
            seen_n = 1'b1;
            ctx_n  = CTX_LIGHTS;
            idx_n  = '0;
            tgt_n  = '0;
          end else if (data == CH_LPAREN && seen) begin
            ctx_n  = CTX_BUTTON;
            acc_n  = '0;
            mask_n = '0;
          end else if (data == CH_LBRACE) begin
            ctx_n = CTX_JOLT;
          end else begin
            err_n = 1'b1;
          end
        end
        CTX_LIGHTS: begin
          if (data == CH_DOT || data == CH_HASH) begin
            if (idx == LW'(MAX_NUM_LIGHTS)) begin
              err_n = 1'b1;
            end else begin
              tgt_n[idx] = (data == CH_HASH);
              idx_n      = idx + 1'b1;
            end
          end else if (data == CH_RBRACK) begin
            nl_n  = idx;
            ctx_n = CTX_IDLE;
          end else begin
            err_n = 1'b1;
          end
        end
        CTX_BUTTON: begin
          if (is_digit) begin
            // Clamping at MAX keeps oversized indices out of range of num_lights.
            acc_n = (acc_ext > 32'(MAX_NUM_LIGHTS)) ? LW'(MAX_NUM_LIGHTS) : acc_ext[LW-1:0];
          end else if (data == CH_COMMA || data == CH_RPAREN) begin
            if (acc >= num_lights) begin
              err_n = 1'b1;
            end else if (data == CH_RPAREN && num_buttons == BW'(MAX_NUM_BUTTONS)) begin
              err_n = 1'b1;
            end else begin
              mask_n[acc] = 1'b1;
              acc_n       = '0;
              if (data == CH_RPAREN) begin
                btn_n[num_buttons] = mask_n;
                nb_n               = num_buttons + 1'b1;
                ctx_n              = CTX_IDLE;
              end
            end
          end else begin
            err_n = 1'b1;
          end
        end
        CTX_JOLT: begin
          if (data == CH_RBRACE) begin
            ctx_n = CTX_IDLE;
          end else if (!is_digit && data != CH_COMMA) begin
            err_n = 1'b1;
          end
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  assign line_end     = beat && (data == CH_NL || last);
  assign unterminated = (ctx_n == CTX_LIGHTS) || (ctx_n == CTX_BUTTON);
  assign line_done    = line_end;
  assign line_error   = beat && (err_n || (line_end && unterminated));
  assign line_valid   = line_end && seen_n && !err_n && !unterminated;

  always_ff @(posedge clk) begin
    if (rst || clear || line_end) begin
      ctx  <= CTX_IDLE;
      idx  <= '0;
      acc  <= '0;
      mask <= '0;
      seen <= 1'b0;
      err  <= 1'b0;
    end else begin
      ctx  <= ctx_n;
      idx  <= idx_n;
      acc  <= acc_n;
      mask <= mask_n;
      seen <= seen_n;
      err  <= err_n;
    end
    // Fields of a launchable line survive the line end until the loader clears them.
    if (rst || clear || (line_end && !line_valid)) begin
      num_lights  <= '0;
      num_buttons <= '0;
      target      <= '0;
      buttons     <= '{default: '0};
    end else begin
      num_lights  <= nl_n;
      num_buttons <= nb_n;
      target      <= tgt_n;
      buttons     <= btn_n;
    end
  end

endmodule

// File: rtl/day10_machine_loader.sv
// Day-10 front end: parses the ASCII stream, hands each machine to the solver
// and totals results. DAY10_LOADER_MACHINE_COUNT_EN adds machine_count.
module day10_machine_loader
  import day10_pkg::*;
#(
  parameter int unsigned MAX_NUM_LIGHTS  = DEF_MAX_NUM_LIGHTS,
  parameter int unsigned MAX_NUM_BUTTONS = DEF_MAX_NUM_BUTTONS,
  parameter int unsigned SUM_W           = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_stream_if.slave             s_axis,
  output logic                    machine_start,
  input  logic                    machine_ready,
  output logic                    machine_accepted,
  day10_input_if.producer         day10_input,
  day10_output_if.consumer        day10_output,
  output logic [SUM_W-1:0]        total_presses,
  output logic                    done,
  output logic                    error
`ifdef DAY10_LOADER_MACHINE_COUNT_EN
  ,
  output logic [15:0]             machine_count
`endif
);

  localparam int unsigned MAX_NUM_LIGHTS_W  = cnt_w(MAX_NUM_LIGHTS);
  localparam int unsigned MAX_NUM_BUTTONS_W = cnt_w(MAX_NUM_BUTTONS);

  loader_state_t state, state_n;
  logic          blank;
  logic          last_seen;
  logic          tready;
  logic          beat;
  logic          clear;
  logic          line_done;
  logic          line_valid;
  logic          line_error;
  logic          unsolvable;

  logic [MAX_NUM_LIGHTS_W-1:0]  num_lights;
  logic [MAX_NUM_BUTTONS_W-1:0] num_buttons;
  logic [MAX_NUM_LIGHTS-1:0]    target;
  logic [MAX_NUM_LIGHTS-1:0]    buttons [MAX_NUM_BUTTONS];

  day10_line_parser #(
    .MAX_NUM_LIGHTS  (MAX_NUM_LIGHTS),
    .MAX_NUM_BUTTONS (MAX_NUM_BUTTONS)
  ) u_parser (
    .clk         (clk),
    .rst         (rst),
    .beat        (beat),
    .data        (s_axis.tdata),
    .last        (s_axis.tlast),
    .clear       (clear),
    .line_done   (line_done),
    .line_valid  (line_valid),
    .line_error  (line_error),
    .num_lights  (num_lights),
    .num_buttons (num_buttons),
    .target      (target),
    .buttons     (buttons)
  );

  assign s_axis.tready                         = tready;
  assign day10_input.num_lights                = num_lights;
  assign day10_input.num_buttons               = num_buttons;
  assign day10_input.target_lights_arrangement = target;
  assign day10_input.buttons                   = buttons;
  assign unsolvable                            = &day10_output.min_button_presses;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_PARSE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n          = state;
    tready           = 1'b0;
    beat             = 1'b0;
    clear            = 1'b0;
    machine_start    = 1'b0;
    machine_accepted = 1'b0;
    done             = 1'b0;
    case (state)
      ST_PARSE: begin
        tready = 1'b1;
        beat   = s_axis.tvalid;
        if (line_done) begin
          if (line_valid) begin
            state_n = ST_LAUNCH;
          end else if (s_axis.tlast) begin
            state_n = ST_FINISH;
          end
        end
      end
      ST_LAUNCH: begin
        machine_start = 1'b1;
        state_n       = ST_WAIT;
      end
      ST_WAIT: begin
        // First WAIT cycle is blanked against a stale ready from the previous accept.
        if (!blank && machine_ready) begin
          state_n = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        machine_accepted = 1'b1;
        clear            = 1'b1;
        state_n          = last_seen ? ST_FINISH : ST_PARSE;
      end
      ST_FINISH: begin
        tready = 1'b1;
        done   = 1'b1;
      end
      default: state_n = ST_PARSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank         <= 1'b0;
      last_seen     <= 1'b0;
      total_presses <= '0;
      error         <= 1'b0;
    end else begin
      blank <= (state == ST_LAUNCH);
      if (state == ST_PARSE && line_done) begin
        last_seen <= s_axis.tlast;
      end
      if (line_error) begin
        error <= 1'b1;
      end
      if (state == ST_COLLECT) begin
        if (unsolvable) begin
          error <= 1'b1;
        end else begin
          total_presses <= total_presses + SUM_W'(day10_output.min_button_presses);
        end
      end
    end
  end

`ifdef DAY10_LOADER_MACHINE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      machine_count <= '0;
    end else if (state == ST_COLLECT && machine_count != 16'hFFFF) begin
      machine_count <= machine_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_day10_machine_loader.sv
// Directed bench for day10_machine_loader with a behavioural solver model.
module tb_day10_machine_loader;

  localparam int unsigned NL    = 10;
  localparam int unsigned NB    = 13;
  localparam int unsigned SUM_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             machine_start;
  logic             machine_ready;
  logic             machine_accepted;
  logic [SUM_W-1:0] total_presses;
  logic             done;
  logic             error;
`ifdef DAY10_LOADER_MACHINE_COUNT_EN
  logic [15:0]      machine_count;
`endif

  axi_stream_if   #(.DATA_WIDTH(8))                               s_axis ();
  day10_input_if  #(.MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB))    in_if ();
  day10_output_if #(.MAX_NUM_BUTTONS(NB))                         out_if ();

  day10_machine_loader #(
    .MAX_NUM_LIGHTS  (NL),
    .MAX_NUM_BUTTONS (NB),
    .SUM_W           (SUM_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (s_axis),
    .machine_start    (machine_start),
    .machine_ready    (machine_ready),
    .machine_accepted (machine_accepted),
    .day10_input      (in_if),
    .day10_output     (out_if),
    .total_presses    (total_presses),
    .done             (done),
    .error            (error)
`ifdef DAY10_LOADER_MACHINE_COUNT_EN
    ,
    .machine_count    (machine_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Solver model: answers from resp_q, ready after a delay, drops one cycle after accept.
  logic [3:0]  resp_q [$];
  bit          stall = 1'b0;
  int unsigned n_start = 0;
  int unsigned n_acc = 0;
  logic [3:0]  cap_nl, cap_nb;
  logic [9:0]  cap_tgt, cap_b1;

  initial begin
    int unsigned countdown = 0;
    bit          pending = 1'b0;
    bit          hold = 1'b0;
    logic [3:0]  resp = '0;
    machine_ready = 1'b0;
    out_if.min_button_presses = '0;
    out_if.buttons_to_press   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        machine_ready = 1'b0;
        pending = 1'b0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          machine_ready = 1'b0;
          hold = 1'b0;
        end
        if (machine_accepted) begin
          n_acc++;
          hold = 1'b1;
        end
        if (machine_start) begin
          n_start++;
          cap_nl  = in_if.num_lights;
          cap_nb  = in_if.num_buttons;
          cap_tgt = in_if.target_lights_arrangement;
          cap_b1  = in_if.buttons[1];
          resp = (resp_q.size() > 0) ? resp_q.pop_front() : 4'd0;
          countdown = (n_start % 2 == 0) ? 5 : 0;
          pending = 1'b1;
        end
        if (pending && !stall) begin
          if (countdown == 0) begin
            machine_ready = 1'b1;
            out_if.min_button_presses = resp;
            pending = 1'b0;
          end else begin
            countdown--;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit l);
    int unsigned waited = 0;
    s_axis.tdata  = b;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    while (!s_axis.tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_axis.tready) check("tready_wait", 64'(s_axis.tready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit last_at_end);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last_at_end && (i == s.len() - 1));
    end
  endtask

  task automatic wait_acc(input int unsigned n);
    int unsigned k = 0;
    while (n_acc < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("accept_count", 64'(n_acc), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned s0, a0, k;
    string       s;
    rst = 1'b1;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_flags", 64'({machine_start, machine_accepted, done, error, s_axis.tready}), 64'h01);
    check("reset_total", 64'(total_presses), 64'd0);
    check("reset_fields", 64'({in_if.num_lights, in_if.num_buttons, in_if.target_lights_arrangement}), 64'd0);

    // File A: three example machines, tlast on the final '}'.
    resp_q.push_back(4'd2);
    send_str("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 1'b0);
    wait_acc(1);
    check("m1_num_lights", 64'(cap_nl), 64'd4);
    check("m1_num_buttons", 64'(cap_nb), 64'd6);
    check("m1_target", 64'(cap_tgt), 64'b0110);
    check("m1_button1", 64'(cap_b1), 64'b1010);
    check("m1_starts", 64'(n_start), 64'd1);
    @(negedge clk);
    check("m1_total", 64'(total_presses), 64'd2);

    resp_q.push_back(4'd3);
    send_str("[...#.] (0,2,3,4) (2,3) (0,4) (0,1,2) (1,2,3,4) {7,5,12,7,2}\n", 1'b0);
    wait_acc(2);
    check("m2_num_lights", 64'(cap_nl), 64'd5);
    check("m2_num_buttons", 64'(cap_nb), 64'd5);
    check("m2_target", 64'(cap_tgt), 64'b01000);
    check("m2_button1", 64'(cap_b1), 64'b01100);
    @(negedge clk);
    check("m2_total", 64'(total_presses), 64'd5);

    resp_q.push_back(4'd2);
    send_str("[.###.#] (0,1,2,3,4) (0,3,4) (0,1,2,4,5) (1,2) {10,11,11,5,1,5,5}", 1'b1);
    wait_acc(3);
    check("m3_num_lights", 64'(cap_nl), 64'd6);
    check("m3_num_buttons", 64'(cap_nb), 64'd4);
    check("m3_target", 64'(cap_tgt), 64'b101110);
    check("m3_button1", 64'(cap_b1), 64'b11001);
    repeat (2) @(negedge clk);
    check("fileA_total", 64'(total_presses), 64'd7);
    check("fileA_done_error", 64'({done, error}), 64'b10);
    check("fileA_starts", 64'(n_start), 64'd3);
    check("fileA_accepts", 64'(n_acc), 64'd3);
    send_byte(8'h0A, 1'b1);
    repeat (3) @(negedge clk);
    check("finish_discard_starts", 64'(n_start), 64'd3);
    check("finish_done_held", 64'(done), 64'd1);

    // File B: unsolvable result, capacity/format errors, blank final line.
    do_reset();
    s0 = n_start;
    a0 = n_acc;
    check("fileB_reset_done", 64'({done, error}), 64'b00);
    resp_q.push_back(4'hF);
    send_str("[.##.] (3) {1}\n", 1'b0);
    wait_acc(a0 + 1);
    @(negedge clk);
    check("unsolvable_error", 64'(error), 64'd1);
    check("unsolvable_total", 64'(total_presses), 64'd0);

    resp_q.push_back(4'd1);
    send_str("[#] (0)\n", 1'b0);
    wait_acc(a0 + 2);
    @(negedge clk);
    check("after_unsolvable_total", 64'(total_presses), 64'd1);

    s = "[..........]";
    for (int i = 0; i < 14; i++) s = {s, " (0)"};
    s = {s, "\n"};
    send_str(s, 1'b0);
    send_str("[..........] (11)\n", 1'b0);
    resp_q.push_back(4'd1);
    send_str("[.#] (1) (0,1)\n", 1'b0);
    wait_acc(a0 + 3);
    check("err_lines_no_start", 64'(n_start), 64'(s0 + 3));
    check("m6_num_buttons", 64'(cap_nb), 64'd2);
    check("m6_target", 64'(cap_tgt), 64'b10);
    check("m6_button1", 64'(cap_b1), 64'b11);
    @(negedge clk);
    check("m6_total", 64'(total_presses), 64'd2);
    send_str("\n", 1'b1);
    repeat (2) @(negedge clk);
    check("fileB_done_error", 64'({done, error}), 64'b11);
    check("fileB_total", 64'(total_presses), 64'd2);

    // File C: reset while the loader waits on the solver.
    do_reset();
    s0 = n_start;
    a0 = n_acc;
    stall = 1'b1;
    resp_q.push_back(4'd1);
    send_str("[#] (0)\n", 1'b0);
    k = 0;
    while (n_start < s0 + 1 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_launch_seen", 64'(n_start), 64'(s0 + 1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_wait_flags", 64'({machine_start, machine_accepted, done, error, s_axis.tready}), 64'h01);
    check("rst_wait_total", 64'(total_presses), 64'd0);
    check("rst_wait_fields", 64'({in_if.num_lights, in_if.num_buttons, in_if.target_lights_arrangement}), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    check("rst_wait_no_accept", 64'(n_acc), 64'(a0));
    resp_q.push_back(4'd1);
    send_str("[.#] (1)\n", 1'b0);
    wait_acc(a0 + 1);
    check("m7_num_lights", 64'(cap_nl), 64'd2);
    check("m7_target", 64'(cap_tgt), 64'b10);
    @(negedge clk);
    check("m7_total", 64'(total_presses), 64'd1);
    send_str("\n", 1'b1);
    repeat (2) @(negedge clk);
    check("fileC_done_error", 64'({done, error}), 64'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
